tl_a_arbiter2: RTL and testbench
================================

Name: tl_a_arbiter2

Overview:
- Two-requester TileLink arbiter. Shares one 64-bit downstream A channel between requesters 0 and 1, and routes D-channel responses back to the requester that issued them.
- Sits upstream of the per-channel buffer block, feeding its A queue and consuming its D queue.
- Grant is round-robin, locked for the whole of a multi-beat data burst and held while a presented beat is stalled.
- The requester index is carried as source MSB.

Parameters:
- BEAT_BYTES, 8, data bytes per beat (fixed; data 64-bit, mask 8-bit).
- MAX_SIZE, 6, largest legal lg2(size). 64 B is 8 beats, so the beat counter is 3 bits.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- r0_a_valid, r1_a_valid  in  1  requester A valid.
- r0_a_ready, r1_a_ready  out  1  requester A ready.
- rN_a_opcode  in  3  requester A opcode.
- rN_a_param  in  3  requester A param.
- rN_a_size  in  4  requester A size.
- rN_a_source  in  4  requester A source.
- rN_a_address  in  32  requester A address.
- rN_a_mask  in  8  requester A mask.
- rN_a_data  in  64  requester A data.
- rN_a_corrupt  in  1  requester A corrupt.
- out_a_valid  out  1  downstream A valid.
- out_a_ready  in  1  downstream A ready.
- out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data, out_a_corrupt  out  as inputs  granted requester's fields.
- out_a_source  out  5  {grant, rN_a_source}.
- out_d_valid  in  1  downstream D valid.
- out_d_ready  out  1  downstream D ready.
- out_d_opcode  in  3  D opcode.
- out_d_param  in  2  D param.
- out_d_size  in  4  D size.
- out_d_source  in  5  D source.
- out_d_data  in  64  D data.
- out_d_denied, out_d_corrupt  in  1  D status flags.
- rN_d_valid  out  1  requester D valid.
- rN_d_ready  in  1  requester D ready.
- rN_d_opcode, rN_d_param, rN_d_size, rN_d_data, rN_d_denied, rN_d_corrupt  out  as out_d  D fields.
- rN_d_source  out  4  out_d_source[3:0].

Behaviour:
- State registers:
  - last (1b): last granted requester. Reset 1, so requester 0 wins first.
  - locked (1b): reset 0.
  - lock_id (1b): reset 0.
  - beats_left (3b): reset 0.
  - hold (1b): set when a presented beat is stalled. Reset 0.
- Arbitration when locked=0 and hold=0 (combinational):
  - Only one valid: grant it.
  - Both valid: grant !last.
  - Neither valid: grant=last, out_a_valid=0.
- When locked=1 or hold=1: grant=lock_id.
- out_a_valid = rgrant_a_valid.
- rgrant_a_ready = out_a_ready. The other requester's ready = 0.
- All out_a fields are a combinational mux of the granted requester. Zero added latency.
- Fire = out_a_valid & out_a_ready.
- Beat count per request:
  - Data opcodes (0..3) with size > 3: 2^(size-3).
  - Everything else: 1 beat.
  - Sizes > MAX_SIZE are illegal and not checked.
- On first-beat fire with count > 1: locked <= 1, lock_id <= grant, beats_left <= count-1.
- Each fire while locked: beats_left decrements. On the fire with beats_left==1: locked <= 0.
- On the final-beat fire (or a single-beat fire): last <= grant.
- Stability rule: if out_a_valid & !out_a_ready while unlocked, then hold <= 1 and lock_id <= grant. hold clears on the next fire. A presented beat's grant never changes before it is accepted.
- D routing: d_sel = out_d_source[4].
  - rN_d_valid = out_d_valid & (d_sel==N).
  - out_d_ready = r[d_sel]_d_ready.
  - Fields broadcast to both requesters.
  - Fully combinational; no state.
- Simultaneous events: a new request arriving on the cycle the last burst beat fires is arbitrated next cycle with the updated last.
- Reset mid-burst: all state returns to reset values and out_a_valid follows inputs next cycle. Downstream must also be reset; no partial-burst recovery.

Test Plan:
- Both valid, single-beat Get (opcode 4, size 3), out_a_ready=1, 4 cycles -> grants alternate 0,1,0,1; out_a_source = 0x0s, 0x1s, 0x0s, 0x1s.
- r0 PutFull size 6 (8 beats) with r1 Get valid throughout -> 8 consecutive r0 beats, r1_a_ready=0 for all 8; r1 granted on cycle 9; last=1 afterwards.
- r0 valid, out_a_ready=0 for 3 cycles, r1 asserts valid in cycle 2 -> grant stays 0 and out_a fields stay r0's until fire; r1 is served next.
- PutFull size 4 (2 beats) with out_a_ready toggling 1,0,1 -> beats_left goes 1 then 0; lock released only after the 2nd fire; total 3 cycles.
- D response with out_d_source=5'h13, r1_d_ready=0 then 1 -> r1_d_valid=1, r0_d_valid=0, r1_d_source=4'h3; out_d_ready follows r1_d_ready (0 then 1).
- Assert reset on beat 4 of an 8-beat burst -> the next cycle has locked=0, beats_left=0, last=1; with both requesters valid, r0 is granted.

Source files
------------

// File: rtl/tl_a_arbiter2.sv
// Two-requester TileLink A-channel arbiter with D-channel return routing.
//
// Requesters 0 and 1 share one 64-bit downstream A channel. Grant is round-robin,
// is locked for every beat of a multi-beat data burst, and is held while a beat
// that is already presented is stalled. The requester index is carried
// downstream as the MSB of out_a_source. D responses are steered back by that
// same bit.
//
// Ports:
//   clock, reset             single clock, synchronous active-high reset
//   rN_a_*                   requester A channels (N = 0, 1)
//   out_a_*                  downstream A channel (source widened by one bit)
//   out_d_*                  downstream D channel
//   rN_d_*                   requester D channels (fields broadcast, valid steered)
module tl_a_arbiter2 #(
  parameter int unsigned BEAT_BYTES = 8,
  parameter int unsigned MAX_SIZE   = 6
) (
  input  logic        clock,
  input  logic        reset,
  // Requester 0 A
  input  logic        r0_a_valid,
  output logic        r0_a_ready,
  input  logic [2:0]  r0_a_opcode,
  input  logic [2:0]  r0_a_param,
  input  logic [3:0]  r0_a_size,
  input  logic [3:0]  r0_a_source,
  input  logic [31:0] r0_a_address,
  input  logic [7:0]  r0_a_mask,
  input  logic [63:0] r0_a_data,
  input  logic        r0_a_corrupt,
  // Requester 1 A
  input  logic        r1_a_valid,
  output logic        r1_a_ready,
  input  logic [2:0]  r1_a_opcode,
  input  logic [2:0]  r1_a_param,
  input  logic [3:0]  r1_a_size,
  input  logic [3:0]  r1_a_source,
  input  logic [31:0] r1_a_address,
  input  logic [7:0]  r1_a_mask,
  input  logic [63:0] r1_a_data,
  input  logic        r1_a_corrupt,
  // Downstream A
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [2:0]  out_a_param,
  output logic [3:0]  out_a_size,
  output logic [4:0]  out_a_source,
  output logic [31:0] out_a_address,
  output logic [7:0]  out_a_mask,
  output logic [63:0] out_a_data,
  output logic        out_a_corrupt,
  // Downstream D
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [1:0]  out_d_param,
  input  logic [3:0]  out_d_size,
  input  logic [4:0]  out_d_source,
  input  logic [63:0] out_d_data,
  input  logic        out_d_denied,
  input  logic        out_d_corrupt,
  // Requester 0 D
  output logic        r0_d_valid,
  input  logic        r0_d_ready,
  output logic [2:0]  r0_d_opcode,
  output logic [1:0]  r0_d_param,
  output logic [3:0]  r0_d_size,
  output logic [3:0]  r0_d_source,
  output logic [63:0] r0_d_data,
  output logic        r0_d_denied,
  output logic        r0_d_corrupt,
  // Requester 1 D
  output logic        r1_d_valid,
  input  logic        r1_d_ready,
  output logic [2:0]  r1_d_opcode,
  output logic [1:0]  r1_d_param,
  output logic [3:0]  r1_d_size,
  output logic [3:0]  r1_d_source,
  output logic [63:0] r1_d_data,
  output logic        r1_d_denied,
  output logic        r1_d_corrupt
);

  logic       last_q;
  logic       locked_q;
  logic       lock_id_q;
  logic [2:0] beats_left_q;
  logic       hold_q;

  logic       grant;
  logic       fire;
  logic [2:0] beats_m1;

  // Grant selection: frozen while a burst is in flight or a stalled beat is shown.
  always_comb begin
    grant = last_q;
    if (locked_q || hold_q) begin
      grant = lock_id_q;
    end else if (r0_a_valid && r1_a_valid) begin
      grant = ~last_q;
    end else if (r0_a_valid) begin
      grant = 1'b0;
    end else if (r1_a_valid) begin
      grant = 1'b1;
    end
  end

  assign out_a_valid   = grant ? r1_a_valid   : r0_a_valid;
  assign out_a_opcode  = grant ? r1_a_opcode  : r0_a_opcode;
  assign out_a_param   = grant ? r1_a_param   : r0_a_param;
  assign out_a_size    = grant ? r1_a_size    : r0_a_size;
  assign out_a_source  = {grant, grant ? r1_a_source : r0_a_source};
  assign out_a_address = grant ? r1_a_address : r0_a_address;
  assign out_a_mask    = grant ? r1_a_mask    : r0_a_mask;
  assign out_a_data    = grant ? r1_a_data    : r0_a_data;
  assign out_a_corrupt = grant ? r1_a_corrupt : r0_a_corrupt;

  assign r0_a_ready = ~grant & out_a_ready;
  assign r1_a_ready = grant & out_a_ready;

  assign fire = out_a_valid & out_a_ready;

  // Beats remaining after the first one. Only data opcodes (0..3, i.e. bit 2
  // clear) above one beat's worth of size carry more than one beat. Sizes beyond
  // MAX_SIZE are illegal and simply map to the largest burst.
  always_comb begin
    beats_m1 = 3'd0;
    if (!out_a_opcode[2]) begin
      unique case (out_a_size)
        4'd0, 4'd1, 4'd2, 4'd3: beats_m1 = 3'd0;
        4'd4:                   beats_m1 = 3'd1;
        4'd5:                   beats_m1 = 3'd3;
        default:                beats_m1 = 3'd7;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_q       <= 1'b1;
      locked_q     <= 1'b0;
      lock_id_q    <= 1'b0;
      beats_left_q <= 3'd0;
      hold_q       <= 1'b0;
    end else if (fire) begin
      hold_q <= 1'b0;
      if (locked_q) begin
        beats_left_q <= beats_left_q - 3'd1;
        if (beats_left_q == 3'd1) begin
          locked_q <= 1'b0;
          last_q   <= grant;
        end
      end else if (beats_m1 != 3'd0) begin
        locked_q     <= 1'b1;
        lock_id_q    <= grant;
        beats_left_q <= beats_m1;
      end else begin
        last_q <= grant;
      end
    end else if (out_a_valid && !locked_q) begin
      // Presented but stalled: pin the grant until this beat is accepted.
      hold_q    <= 1'b1;
      lock_id_q <= grant;
    end
  end

  // D routing is purely combinational on the source MSB.
  logic d_sel;
  assign d_sel = out_d_source[4];

  assign r0_d_valid  = out_d_valid & ~d_sel;
  assign r1_d_valid  = out_d_valid & d_sel;
  assign out_d_ready = d_sel ? r1_d_ready : r0_d_ready;

  assign r0_d_opcode  = out_d_opcode;
  assign r0_d_param   = out_d_param;
  assign r0_d_size    = out_d_size;
  assign r0_d_source  = out_d_source[3:0];
  assign r0_d_data    = out_d_data;
  assign r0_d_denied  = out_d_denied;
  assign r0_d_corrupt = out_d_corrupt;
  assign r1_d_opcode  = out_d_opcode;
  assign r1_d_param   = out_d_param;
  assign r1_d_size    = out_d_size;
  assign r1_d_source  = out_d_source[3:0];
  assign r1_d_data    = out_d_data;
  assign r1_d_denied  = out_d_denied;
  assign r1_d_corrupt = out_d_corrupt;

endmodule

// File: tb/tb_tl_a_arbiter2.sv
// Directed self-checking bench for tl_a_arbiter2.
module tb_tl_a_arbiter2;

  logic        clock = 1'b0;
  logic        reset;
  logic        r0_a_valid, r0_a_ready, r0_a_corrupt;
  logic [2:0]  r0_a_opcode, r0_a_param;
  logic [3:0]  r0_a_size, r0_a_source;
  logic [31:0] r0_a_address;
  logic [7:0]  r0_a_mask;
  logic [63:0] r0_a_data;
  logic        r1_a_valid, r1_a_ready, r1_a_corrupt;
  logic [2:0]  r1_a_opcode, r1_a_param;
  logic [3:0]  r1_a_size, r1_a_source;
  logic [31:0] r1_a_address;
  logic [7:0]  r1_a_mask;
  logic [63:0] r1_a_data;
  logic        out_a_valid, out_a_ready, out_a_corrupt;
  logic [2:0]  out_a_opcode, out_a_param;
  logic [3:0]  out_a_size;
  logic [4:0]  out_a_source;
  logic [31:0] out_a_address;
  logic [7:0]  out_a_mask;
  logic [63:0] out_a_data;
  logic        out_d_valid, out_d_ready, out_d_denied, out_d_corrupt;
  logic [2:0]  out_d_opcode;
  logic [1:0]  out_d_param;
  logic [3:0]  out_d_size;
  logic [4:0]  out_d_source;
  logic [63:0] out_d_data;
  logic        r0_d_valid, r0_d_ready, r0_d_denied, r0_d_corrupt;
  logic [2:0]  r0_d_opcode;
  logic [1:0]  r0_d_param;
  logic [3:0]  r0_d_size, r0_d_source;
  logic [63:0] r0_d_data;
  logic        r1_d_valid, r1_d_ready, r1_d_denied, r1_d_corrupt;
  logic [2:0]  r1_d_opcode;
  logic [1:0]  r1_d_param;
  logic [3:0]  r1_d_size, r1_d_source;
  logic [63:0] r1_d_data;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  tl_a_arbiter2 dut (
    .clock(clock), .reset(reset),
    .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready), .r0_a_opcode(r0_a_opcode),
    .r0_a_param(r0_a_param), .r0_a_size(r0_a_size), .r0_a_source(r0_a_source),
    .r0_a_address(r0_a_address), .r0_a_mask(r0_a_mask), .r0_a_data(r0_a_data),
    .r0_a_corrupt(r0_a_corrupt),
    .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready), .r1_a_opcode(r1_a_opcode),
    .r1_a_param(r1_a_param), .r1_a_size(r1_a_size), .r1_a_source(r1_a_source),
    .r1_a_address(r1_a_address), .r1_a_mask(r1_a_mask), .r1_a_data(r1_a_data),
    .r1_a_corrupt(r1_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_data(out_d_data), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .r0_d_valid(r0_d_valid), .r0_d_ready(r0_d_ready), .r0_d_opcode(r0_d_opcode),
    .r0_d_param(r0_d_param), .r0_d_size(r0_d_size), .r0_d_source(r0_d_source),
    .r0_d_data(r0_d_data), .r0_d_denied(r0_d_denied), .r0_d_corrupt(r0_d_corrupt),
    .r1_d_valid(r1_d_valid), .r1_d_ready(r1_d_ready), .r1_d_opcode(r1_d_opcode),
    .r1_d_param(r1_d_param), .r1_d_size(r1_d_size), .r1_d_source(r1_d_source),
    .r1_d_data(r1_d_data), .r1_d_denied(r1_d_denied), .r1_d_corrupt(r1_d_corrupt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset = 1'b1;
    r0_a_valid = 0; r0_a_opcode = 3'd4; r0_a_param = 3'd0; r0_a_size = 4'd3;
    r0_a_source = 4'h5; r0_a_address = 32'h0000_1000; r0_a_mask = 8'hff;
    r0_a_data = 64'h0; r0_a_corrupt = 0;
    r1_a_valid = 0; r1_a_opcode = 3'd4; r1_a_param = 3'd0; r1_a_size = 4'd3;
    r1_a_source = 4'hA; r1_a_address = 32'h0000_2000; r1_a_mask = 8'h0f;
    r1_a_data = 64'h0; r1_a_corrupt = 0;
    out_a_ready = 0;
    out_d_valid = 0; out_d_opcode = 3'd1; out_d_param = 2'd0; out_d_size = 4'd3;
    out_d_source = 5'h00; out_d_data = 64'h0; out_d_denied = 0; out_d_corrupt = 0;
    r0_d_ready = 0; r1_d_ready = 0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    settle();
    chk("rst_out_valid", 64'(out_a_valid), 64'd0);
    chk("rst_locked", 64'(dut.locked_q), 64'd0);
    chk("rst_last", 64'(dut.last_q), 64'd1);

    // Round-robin single-beat Gets: 0,1,0,1
    r0_a_valid = 1; r1_a_valid = 1; out_a_ready = 1;
    settle();
    chk("rr0_src", 64'(out_a_source), 64'h05);
    chk("rr0_addr", 64'(out_a_address), 64'h1000);
    chk("rr0_r1rdy", 64'(r1_a_ready), 64'd0);
    tick();
    chk("rr1_src", 64'(out_a_source), 64'h1A);
    chk("rr1_mask", 64'(out_a_mask), 64'h0f);
    chk("rr1_r1rdy", 64'(r1_a_ready), 64'd1);
    tick();
    chk("rr2_src", 64'(out_a_source), 64'h05);
    tick();
    chk("rr3_src", 64'(out_a_source), 64'h1A);
    tick();

    // r0 8-beat PutFull, r1 Get waiting throughout
    r0_a_opcode = 3'd0; r0_a_size = 4'd6;
    for (int i = 0; i < 8; i++) begin
      r0_a_data = 64'hD0 + 64'(i);
      settle();
      chk("burst_src", 64'(out_a_source), 64'h05);
      chk("burst_data", out_a_data, 64'hD0 + 64'(i));
      chk("burst_r1rdy", 64'(r1_a_ready), 64'd0);
      if (i == 1) begin
        chk("burst_locked", 64'(dut.locked_q), 64'd1);
        chk("burst_bl", 64'(dut.beats_left_q), 64'd7);
      end
      tick();
    end
    chk("post_burst_src", 64'(out_a_source), 64'h1A);
    chk("post_burst_r1rdy", 64'(r1_a_ready), 64'd1);
    tick();
    chk("post_burst_last", 64'(dut.last_q), 64'd1);
    r0_a_valid = 0; r1_a_valid = 0;
    r0_a_opcode = 3'd4; r0_a_size = 4'd3;

    // Make last=0 with a single r0 Get, then stall r0 while r1 arrives
    r0_a_valid = 1;
    settle();
    chk("pre_hold_src", 64'(out_a_source), 64'h05);
    tick();
    out_a_ready = 0;
    settle();
    chk("hold1_src", 64'(out_a_source), 64'h05);
    chk("hold1_r0rdy", 64'(r0_a_ready), 64'd0);
    tick();
    r1_a_valid = 1;
    settle();
    chk("hold2_src", 64'(out_a_source), 64'h05);
    chk("hold2_addr", 64'(out_a_address), 64'h1000);
    tick();
    settle();
    chk("hold3_src", 64'(out_a_source), 64'h05);
    out_a_ready = 1;
    settle();
    chk("hold_fire_r0rdy", 64'(r0_a_ready), 64'd1);
    tick();
    chk("hold_next_src", 64'(out_a_source), 64'h1A);
    tick();
    r0_a_valid = 0; r1_a_valid = 0;

    // r1 2-beat PutFull with ready 1,0,1
    r1_a_opcode = 3'd0; r1_a_size = 4'd4; r1_a_valid = 1;
    settle();
    chk("pf2_b0_src", 64'(out_a_source), 64'h1A);
    tick();
    chk("pf2_bl1", 64'(dut.beats_left_q), 64'd1);
    out_a_ready = 0; r0_a_valid = 1;
    settle();
    chk("pf2_stall_src", 64'(out_a_source), 64'h1A);
    chk("pf2_stall_r0rdy", 64'(r0_a_ready), 64'd0);
    tick();
    chk("pf2_stall_locked", 64'(dut.locked_q), 64'd1);
    out_a_ready = 1;
    settle();
    chk("pf2_b1_r1rdy", 64'(r1_a_ready), 64'd1);
    tick();
    chk("pf2_bl0", 64'(dut.beats_left_q), 64'd0);
    chk("pf2_unlocked", 64'(dut.locked_q), 64'd0);
    r1_a_valid = 0;
    settle();
    chk("pf2_after_src", 64'(out_a_source), 64'h05);
    r0_a_valid = 0;
    r1_a_opcode = 3'd4; r1_a_size = 4'd3;

    // D routing
    out_d_valid = 1; out_d_source = 5'h13; out_d_data = 64'hCAFE_F00D;
    r0_d_ready = 1; r1_d_ready = 0;
    settle();
    chk("d_r1_valid", 64'(r1_d_valid), 64'd1);
    chk("d_r0_valid", 64'(r0_d_valid), 64'd0);
    chk("d_r1_source", 64'(r1_d_source), 64'h3);
    chk("d_r1_data", r1_d_data, 64'hCAFE_F00D);
    chk("d_ready0", 64'(out_d_ready), 64'd0);
    r1_d_ready = 1;
    settle();
    chk("d_ready1", 64'(out_d_ready), 64'd1);
    out_d_source = 5'h05; r0_d_ready = 0;
    settle();
    chk("d_r0_sel_valid", 64'(r0_d_valid), 64'd1);
    chk("d_r0_sel_ready", 64'(out_d_ready), 64'd0);
    out_d_valid = 0;
    tick();

    // Reset on beat 4 of an 8-beat r0 burst
    r0_a_opcode = 3'd0; r0_a_size = 4'd6; r0_a_valid = 1; r1_a_valid = 1;
    settle();
    chk("rb_src", 64'(out_a_source), 64'h05);
    tick(); tick(); tick();
    chk("rb_bl", 64'(dut.beats_left_q), 64'd5);
    reset = 1;
    tick();
    reset = 0;
    settle();
    chk("rb_locked", 64'(dut.locked_q), 64'd0);
    chk("rb_bl0", 64'(dut.beats_left_q), 64'd0);
    chk("rb_last", 64'(dut.last_q), 64'd1);
    chk("rb_grant_src", 64'(out_a_source), 64'h05);
    chk("rb_r1rdy", 64'(r1_a_ready), 64'd0);
    r0_a_valid = 0; r1_a_valid = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
